// File: rtl/chu_uart_ext_pkg.sv
// Shared definitions for the configurable slot UART: register map, ctrl layout,
// frame format decoding and parity helpers.
package chu_uart_ext_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_LEVEL   = 3'd1;
  localparam logic [2:0] ADDR_CTRL_RD = 3'd2;
  localparam logic [2:0] ADDR_DVSR    = 3'd1;
  localparam logic [2:0] ADDR_TX_DATA = 3'd2;
  localparam logic [2:0] ADDR_RX_POP  = 3'd3;
  localparam logic [2:0] ADDR_CTRL_WR = 3'd4;
  localparam logic [2:0] ADDR_ERR_CLR = 3'd5;

  localparam int CTRL_DBITS_LSB = 0;
  localparam int CTRL_PAR_LSB   = 2;
  localparam int CTRL_STOP2     = 4;
  localparam int CTRL_RX_IE     = 5;
  localparam int CTRL_TX_IE     = 6;
  localparam int CTRL_ERR_IE    = 7;
  localparam logic [7:0] CTRL_RESET = 8'h03;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic [1:0] dbits;
    parity_e    parity;
    logic       stop2;
  } frame_fmt_t;

  function automatic frame_fmt_t decode_fmt(input logic [7:0] ctrl);
    frame_fmt_t f;
    f.dbits = ctrl[CTRL_DBITS_LSB +: 2];
    case (ctrl[CTRL_PAR_LSB +: 2])
      2'b01:   f.parity = PAR_EVEN;
      2'b10:   f.parity = PAR_ODD;
      default: f.parity = PAR_NONE;
    endcase
    f.stop2 = ctrl[CTRL_STOP2];
    return f;
  endfunction

  // dbits encodes N-5, so {1, dbits} is the index of the last data bit.
  function automatic logic [2:0] last_bit(input logic [1:0] dbits);
    return {1'b1, dbits};
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input frame_fmt_t f);
    logic [1:0] sh;
    logic [7:0] mask;
    sh   = 2'd3 - f.dbits;
    mask = 8'hFF >> sh;
    return (^(data & mask)) ^ (f.parity == PAR_ODD);
  endfunction

endpackage

// File: rtl/chu_uart_ext_if.sv
// MMIO slot bus between the processor-side master and the UART core.
interface chu_uart_ext_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_uart_ext_fifo.sv
// Synchronous FIFO with fill level; pushes when full and pops when empty are ignored.
module chu_uart_ext_fifo #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              wr_ok, rd_ok;

  assign empty  = (level_q == '0);
  assign full   = level_q[ADDR_W];
  assign wr_ok  = wr & ~full;
  assign rd_ok  = rd & ~empty;
  assign r_data = mem[rptr_q];
  assign level  = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/chu_uart_ext_rx.sv
// Receive path: rx synchroniser and 16x oversampling frame FSM that reports each
// character with one-cycle done/perr/ferr strobes.
module uart_rx_frame
  import chu_uart_ext_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       tick,
  input  frame_fmt_t fmt,
  output logic [7:0] data,
  output logic       done,
  output logic       perr,
  output logic       ferr
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             data_q, data_d;
  frame_fmt_t             fmt_q, fmt_d;
  logic                   par_err_q, par_err_d;
  logic                   done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign data = data_q;
  assign done = done_q;
  assign perr = perr_q;
  assign ferr = ferr_q;

  always_comb begin
    sync_d     = (sync_q << 1) | SYNC_STAGES'(rx);
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    fmt_d      = fmt_q;
    par_err_d  = par_err_q;
    done_d     = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
          fmt_d      = fmt;
        end
      end
      RX_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            if (rx_s) begin
              state_d = RX_IDLE;
            end else begin
              state_d    = RX_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              data_d     = '0;
              par_err_d  = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d        = '0;
            data_d[bit_cnt_q] = rx_s;
            if (bit_cnt_q == last_bit(fmt_q.dbits)) begin
              state_d = (fmt_q.parity == PAR_NONE) ? RX_STOP : RX_PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            par_err_d  = (rx_s != calc_parity(data_q, fmt_q));
            state_d    = RX_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            state_d = RX_IDLE;
            done_d  = 1'b1;
            perr_d  = par_err_q;
            ferr_d  = ~rx_s;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '1;
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      fmt_q      <= decode_fmt(CTRL_RESET);
      par_err_q  <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      fmt_q      <= fmt_d;
      par_err_q  <= par_err_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule

// File: rtl/chu_uart_ext.sv
// Configurable slot UART: register file, baud tick generator, TX frame FSM,
// receive path and two character FIFOs.
module chu_uart_ext
  import chu_uart_ext_pkg::*;
#(
  parameter int FIFO_DEPTH_BIT = 8,
  parameter int DVSR_W         = 11,
  parameter int RX_SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  chu_uart_ext_if.slave  bus,
  output logic           tx,
  input  logic           rx,
  output logic           irq
);

  logic [DVSR_W-1:0]     dvsr_q, dvsr_d, dvsr_act_q, dvsr_act_d, baud_cnt_q, baud_cnt_d;
  logic                  tick;
  logic [7:0]            ctrl_q, ctrl_d;
  frame_fmt_t            ctrl_fmt;
  logic                  perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d, irq_q, irq_d;
  logic [2:0]            err_clr;
  logic                  wr_en, unused_bus;
  logic [2:0]            wr_addr;

  logic                  tx_push, tx_pop, tx_empty, tx_full, tx_idle;
  logic [7:0]            tx_head;
  logic [FIFO_DEPTH_BIT:0] tx_level;
  logic                  rx_pop, rx_empty, rx_full, rx_done, rx_perr, rx_ferr;
  logic [7:0]            rx_head, rx_data;
  logic [FIFO_DEPTH_BIT:0] rx_level;

  tx_state_e             tx_state_q, tx_state_d;
  logic [4:0]            tx_tick_q, tx_tick_d;
  logic [2:0]            tx_bit_q, tx_bit_d;
  logic [7:0]            tx_shreg_q, tx_shreg_d;
  frame_fmt_t            tx_fmt_q, tx_fmt_d;
  logic                  tx_par_q, tx_par_d, tx_q, tx_d;

  assign wr_en      = bus.cs & bus.write;
  assign wr_addr    = bus.addr[2:0];
  assign tx_push    = wr_en && (wr_addr == ADDR_TX_DATA);
  assign rx_pop     = wr_en && (wr_addr == ADDR_RX_POP);
  assign ctrl_fmt   = decode_fmt(ctrl_q);
  assign tx_idle    = (tx_state_q == TX_IDLE) & tx_empty;
  assign tx         = tx_q;
  assign irq        = irq_q;
  assign unused_bus = &{1'b0, bus.read, bus.addr, bus.wr_data};

  chu_uart_ext_fifo #(.ADDR_W(FIFO_DEPTH_BIT), .DATA_W(8)) u_tx_fifo (
    .clk(clk), .reset(reset), .wr(tx_push), .rd(tx_pop), .w_data(bus.wr_data[7:0]),
    .r_data(tx_head), .empty(tx_empty), .full(tx_full), .level(tx_level)
  );

  chu_uart_ext_fifo #(.ADDR_W(FIFO_DEPTH_BIT), .DATA_W(8)) u_rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_done), .rd(rx_pop), .w_data(rx_data),
    .r_data(rx_head), .empty(rx_empty), .full(rx_full), .level(rx_level)
  );

  uart_rx_frame #(.SYNC_STAGES(RX_SYNC_STAGES)) u_rx (
    .clk(clk), .reset(reset), .rx(rx), .tick(tick), .fmt(ctrl_fmt),
    .data(rx_data), .done(rx_done), .perr(rx_perr), .ferr(rx_ferr)
  );

  // The divisor in use is only refreshed on a wrap so a write never truncates a period.
  always_comb begin
    tick       = (baud_cnt_q == dvsr_act_q);
    baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    dvsr_act_d = tick ? dvsr_q : dvsr_act_q;
  end

  always_comb begin
    dvsr_d  = dvsr_q;
    ctrl_d  = ctrl_q;
    err_clr = '0;
    if (wr_en) begin
      case (wr_addr)
        ADDR_DVSR:    dvsr_d  = bus.wr_data[DVSR_W-1:0];
        ADDR_CTRL_WR: ctrl_d  = bus.wr_data[7:0];
        ADDR_ERR_CLR: err_clr = bus.wr_data[2:0];
        default: ;
      endcase
    end
    perr_d = (perr_q & ~err_clr[0]) | rx_perr;
    ferr_d = (ferr_q & ~err_clr[1]) | rx_ferr;
    ovr_d  = (ovr_q  & ~err_clr[2]) | (rx_done & rx_full);
    irq_d  = (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & tx_empty) |
             (ctrl_q[CTRL_ERR_IE] & (perr_q | ferr_q | ovr_q));
  end

  always_comb begin
    bus.rd_data = '0;
    case (wr_addr)
      ADDR_STATUS:  bus.rd_data = {18'd0, tx_idle, ovr_q, ferr_q, perr_q, tx_full, rx_empty,
                                   (rx_empty ? 8'h00 : rx_head)};
      ADDR_LEVEL:   bus.rd_data = {16'(rx_level), 16'(tx_level)};
      ADDR_CTRL_RD: bus.rd_data[7:0] = ctrl_q;
      default: ;
    endcase
  end

  // tx_d is the line level for the state being entered, keeping tx a clean flop output.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_fmt_d   = tx_fmt_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_fmt_d   = ctrl_fmt;
          tx_shreg_d = tx_head;
          tx_par_d   = calc_parity(tx_head, ctrl_fmt);
          tx_tick_d  = '0;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_tick_q == 5'd15) begin
            tx_tick_d  = '0;
            tx_bit_d   = '0;
            tx_d       = tx_shreg_q[0];
            tx_state_d = TX_DATA;
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tick_q == 5'd15) begin
            tx_tick_d  = '0;
            tx_shreg_d = tx_shreg_q >> 1;
            if (tx_bit_q == last_bit(tx_fmt_q.dbits)) begin
              if (tx_fmt_q.parity == PAR_NONE) begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
              end else begin
                tx_state_d = TX_PARITY;
                tx_d       = tx_par_q;
              end
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
              tx_d     = tx_shreg_q[1];
            end
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_tick_q == 5'd15) begin
            tx_tick_d  = '0;
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_tick_q == {tx_fmt_q.stop2, 4'hF}) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr_q     <= '0;
      dvsr_act_q <= '0;
      baud_cnt_q <= '0;
      ctrl_q     <= CTRL_RESET;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_fmt_q   <= decode_fmt(CTRL_RESET);
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      dvsr_q     <= dvsr_d;
      dvsr_act_q <= dvsr_act_d;
      baud_cnt_q <= baud_cnt_d;
      ctrl_q     <= ctrl_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      irq_q      <= irq_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_fmt_q   <= tx_fmt_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_chu_uart_ext.sv
// Directed bench for chu_uart_ext: loopback frames, bench-driven error frames,
// overrun with a 4-entry FIFO and reset during transmission.
module tb_chu_uart_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx, irq;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic [31:0] v;
  int          checks = 0;
  int          errors = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  chu_uart_ext_if bus ();

  chu_uart_ext #(.FIFO_DEPTH_BIT(2), .DVSR_W(11), .RX_SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .rx(rx_line), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = {2'b00, a}; bus.wr_data = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = {2'b00, a}; bus.cs = 1'b1; bus.read = 1'b1;
    #1 d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  // Samples the tx line roughly mid-bit (7 cycles in) for each field at dvsr=0.
  task automatic sampleTxFrame(input string tag, input int nbits, input logic [7:0] data,
                               input logic par_en, input logic par_exp, input logic stop2);
    int          wait_cnt;
    logic [7:0]  got;
    logic [31:0] st;
    wait_cnt = 0;
    do begin
      @(posedge clk); #1;
      wait_cnt++;
    end while (tx !== 1'b0 && wait_cnt < 400);
    if (tx !== 1'b0) begin
      checkOutput({tag, "_start_timeout"}, 32'(tx), 32'd0);
      return;
    end
    repeat (7) @(posedge clk); #1;
    checkOutput({tag, "_start"}, 32'(tx), 32'd0);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      repeat (16) @(posedge clk); #1;
      got[i] = tx;
    end
    checkOutput({tag, "_data"}, 32'(got), 32'(data));
    if (par_en) begin
      repeat (16) @(posedge clk); #1;
      checkOutput({tag, "_parity"}, 32'(tx), 32'(par_exp));
    end
    repeat (16) @(posedge clk); #1;
    checkOutput({tag, "_stop1"}, 32'(tx), 32'd1);
    if (stop2) begin
      repeat (15) @(posedge clk);
      readReg(3'd0, st);
      checkOutput({tag, "_stop2_busy"}, 32'(st[13]), 32'd0);
      checkOutput({tag, "_stop2_line"}, 32'(tx), 32'd1);
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic sendRxFrame(input logic [7:0] data, input int nbits, input logic par_en,
                             input logic par_bit, input logic stop_val, input int stop_len);
    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (16) @(posedge clk); #1;
    for (int i = 0; i < nbits; i++) begin
      rx_drv = data[i];
      repeat (16) @(posedge clk); #1;
    end
    if (par_en) begin
      rx_drv = par_bit;
      repeat (16) @(posedge clk); #1;
    end
    rx_drv = stop_val;
    repeat (stop_len) @(posedge clk); #1;
    rx_drv = 1'b1;
    repeat (24) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] ovr_data [5];
    int         wait_cnt;
    ovr_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    readReg(3'd0, v); checkOutput("reset_status", v, 32'h0000_2100);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    readReg(3'd2, v); checkOutput("reset_ctrl", v, 32'h0000_0003);
    readReg(3'd1, v); checkOutput("reset_levels", v, 32'h0);

    // 8N1 loopback of 0xA5
    loop_en = 1'b1;
    applyStimulus(3'd1, 32'd0);
    applyStimulus(3'd2, 32'h0000_00A5);
    sampleTxFrame("a5", 8, 8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    readReg(3'd0, v);
    checkOutput("a5_rx_data", 32'(v[7:0]), 32'h0000_00A5);
    checkOutput("a5_rx_empty", 32'(v[8]), 32'd0);
    readReg(3'd1, v); checkOutput("a5_rx_level", 32'(v[31:16]), 32'd1);
    applyStimulus(3'd3, 32'd0);

    // 7E2 loopback, parity 0 then 1
    applyStimulus(3'd4, 32'h0000_0016);
    applyStimulus(3'd2, 32'h0000_0041);
    sampleTxFrame("e41", 7, 8'h41, 1'b1, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    readReg(3'd0, v); checkOutput("e41_rx_data", 32'(v[8:0]), 32'h0000_0041);
    applyStimulus(3'd3, 32'd0);
    applyStimulus(3'd2, 32'h0000_0043);
    sampleTxFrame("e43", 7, 8'h43, 1'b1, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    readReg(3'd0, v); checkOutput("e43_rx_data", 32'(v[8:0]), 32'h0000_0043);
    applyStimulus(3'd3, 32'd0);

    // bench-driven 8E1 error frames
    loop_en = 1'b0;
    applyStimulus(3'd4, 32'h0000_0007);
    sendRxFrame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 16);
    readReg(3'd0, v);
    checkOutput("perr_flag", 32'(v[12:10]), 32'b001);
    checkOutput("perr_data", 32'(v[8:0]), 32'h0000_003C);
    applyStimulus(3'd3, 32'd0);
    sendRxFrame(8'h5A, 8, 1'b1, 1'b0, 1'b0, 12);
    readReg(3'd0, v);
    checkOutput("ferr_flag", 32'(v[12:10]), 32'b011);
    checkOutput("ferr_data", 32'(v[8:0]), 32'h0000_005A);
    applyStimulus(3'd3, 32'd0);
    applyStimulus(3'd5, 32'h0000_0003);
    readReg(3'd0, v); checkOutput("err_clear", 32'(v[12:8]), 32'b00001);

    // 5-cycle glitch
    @(posedge clk); #1 rx_drv = 1'b0;
    repeat (5) @(posedge clk); #1 rx_drv = 1'b1;
    repeat (100) @(posedge clk);
    readReg(3'd1, v); checkOutput("glitch_level", 32'(v[31:16]), 32'd0);
    readReg(3'd0, v); checkOutput("glitch_empty", 32'(v[8]), 32'd1);

    // overrun with a 4-deep rx FIFO
    applyStimulus(3'd4, 32'h0000_0083);
    repeat (3) @(posedge clk); #1;
    checkOutput("irq_quiet", 32'(irq), 32'd0);
    for (int k = 0; k < 5; k++) sendRxFrame(ovr_data[k], 8, 1'b0, 1'b0, 1'b1, 16);
    readReg(3'd1, v); checkOutput("ovr_level", 32'(v[31:16]), 32'd4);
    readReg(3'd0, v); checkOutput("ovr_flag", 32'(v[12]), 32'd1);
    checkOutput("ovr_irq", 32'(irq), 32'd1);
    for (int k = 0; k < 4; k++) begin
      readReg(3'd0, v);
      checkOutput($sformatf("ovr_pop%0d", k), 32'(v[7:0]), 32'(ovr_data[k]));
      applyStimulus(3'd3, 32'd0);
    end
    readReg(3'd0, v); checkOutput("ovr_drained", 32'(v[8]), 32'd1);
    applyStimulus(3'd5, 32'h0000_0004);
    repeat (3) @(posedge clk); #1;
    checkOutput("ovr_irq_clear", 32'(irq), 32'd0);

    // reset in the middle of a transmitted frame
    applyStimulus(3'd4, 32'h0000_0003);
    applyStimulus(3'd2, 32'h0000_005A);
    applyStimulus(3'd2, 32'h0000_0077);
    wait_cnt = 0;
    while (tx !== 1'b0 && wait_cnt < 400) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    repeat (20) @(posedge clk); #1;
    checkOutput("midframe_low", 32'(tx), 32'd0);
    reset = 1'b0;
    #1 checkOutput("midframe_reset_tx", 32'(tx), 32'd1);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    readReg(3'd0, v); checkOutput("post_reset_idle", 32'(v[13]), 32'd1);
    readReg(3'd1, v); checkOutput("post_reset_txlvl", 32'(v[15:0]), 32'd0);
    loop_en = 1'b1;
    applyStimulus(3'd2, 32'h0000_003C);
    sampleTxFrame("post", 8, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    readReg(3'd0, v); checkOutput("post_rx_data", 32'(v[8:0]), 32'h0000_003C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
